// File: rtl/calc_multi_engine.sv
// Multi-port calculator: NUM_PORTS command/operand channels share one registered-grant ALU.
// Each lane runs IDLE->OP2->PEND->RESP; the arbiter grants one pending lane per cycle.

module calc_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [3:0]        cmd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              gnt_i,
    input  logic [DATA_W-1:0] res_data_i,
    input  logic [1:0]        res_resp_i,
    output logic              pend_o,
    output logic [3:0]        cmd_o,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_resp_o
);
    typedef enum logic [1:0] {IDLE, OP2, PEND, RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
    logic [1:0]        resp_q, resp_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            data_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

    // Output registers default to zero so a result is visible for exactly one cycle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        data_d  = '0;
        resp_d  = '0;
        case (state_q)
            IDLE: if (cmd_i != 4'd0) begin
                cmd_d   = cmd_i;
                op1_d   = data_i;
                state_d = OP2;
            end
            OP2: begin
                op2_d   = data_i;
                state_d = PEND;
            end
            PEND: if (gnt_i) begin
                data_d  = res_data_i;
                resp_d  = res_resp_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pend_o     = (state_q == PEND);
    assign cmd_o      = cmd_q;
    assign op1_o      = op1_q;
    assign op2_o      = op2_q;
    assign out_data_o = data_q;
    assign out_resp_o = resp_q;
endmodule

module calc_multi_engine #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 1
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
    output logic [DATA_W*NUM_PORTS-1:0]   out_data,
    output logic [2*NUM_PORTS-1:0]        out_resp
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]             pend, req, gnt_q, gnt_d;
    logic [NUM_PORTS-1:0][3:0]        cmd;
    logic [NUM_PORTS-1:0][DATA_W-1:0] op1, op2;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [3:0]                       a_cmd;
    logic [DATA_W-1:0]                a1, a2, alu_data;
    logic [DATA_W:0]                  sum;
    logic [1:0]                       alu_resp;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        calc_lane #(.DATA_W(DATA_W)) u_lane (
            .clk_i      (c_clk),
            .rst_ni     (reset),
            .cmd_i      (req_cmd_in[4*i +: 4]),
            .data_i     (req_data_in[DATA_W*i +: DATA_W]),
            .gnt_i      (gnt_q[i]),
            .res_data_i (alu_data),
            .res_resp_i (alu_resp),
            .pend_o     (pend[i]),
            .cmd_o      (cmd[i]),
            .op1_o      (op1[i]),
            .op2_o      (op2[i]),
            .out_data_o (out_data[DATA_W*i +: DATA_W]),
            .out_resp_o (out_resp[2*i +: 2])
        );
    end

    // A lane holding the registered grant is still in PEND this cycle; keep it out of the race.
    assign req = pend & ~gnt_q;

    always_comb begin
        automatic int   idx   = 0;
        automatic logic found = 1'b0;
        gnt_d = '0;
        ptr_d = ptr_q;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_d    = '0;
                    gnt_d[i] = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(ptr_q) + k) % NUM_PORTS;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    gnt_d[idx] = 1'b1;
                    ptr_d      = PTR_W'((idx + 1) % NUM_PORTS);
                end
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        a_cmd = '0;
        a1    = '0;
        a2    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_q[i]) begin
                a_cmd = cmd[i];
                a1    = op1[i];
                a2    = op2[i];
            end
        end
    end

    // Error cases (carry, borrow, unknown opcode) fall through to resp 2 / data 0.
    assign sum = {1'b0, a1} + {1'b0, a2};

    always_comb begin
        alu_data = '0;
        alu_resp = 2'd2;
        case (a_cmd)
            4'd1: if (!sum[DATA_W]) begin
                alu_data = sum[DATA_W-1:0];
                alu_resp = 2'd1;
            end
            4'd2: if (a2 <= a1) begin
                alu_data = a1 - a2;
                alu_resp = 2'd1;
            end
            4'd5: begin
                alu_data = a1 << a2[SH_W-1:0];
                alu_resp = 2'd1;
            end
            4'd6: begin
                alu_data = a1 >> a2[SH_W-1:0];
                alu_resp = 2'd1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_multi_engine.sv
// Bench for calc_multi_engine: fixed-priority and round-robin instances side by side,
// expected responses queued at issue time and matched (port, data, resp, cycle) as they appear.

module tb_calc_multi_engine;
    localparam int NP = 4;
    localparam int DW = 32;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    always #5 c_clk = ~c_clk;

    logic [NP-1:0][3:0]    cmd0, cmd1;
    logic [NP-1:0][DW-1:0] din0, din1, dout0, dout1;
    logic [NP-1:0][1:0]    resp0, resp1;

    calc_multi_engine #(.NUM_PORTS(NP), .DATA_W(DW), .ARB_MODE(0)) dut0 (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd0), .req_data_in(din0),
        .out_data(dout0), .out_resp(resp0));
    calc_multi_engine #(.NUM_PORTS(NP), .DATA_W(DW), .ARB_MODE(1)) dut1 (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd1), .req_data_in(din1),
        .out_data(dout1), .out_resp(resp1));

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    exp_t q0[$], q1[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic [NP-1:0][1:0] r, input logic [NP-1:0][DW-1:0] dd);
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (r[p] == 2'd0)
                chk($sformatf("dut%0d_p%0d_idle_data", d, p), 64'(dd[p]), 64'd0);
            else if ((d == 0 ? q0.size() : q1.size()) == 0)
                chk($sformatf("dut%0d_p%0d_unexpected_resp", d, p), 64'(r[p]), 64'd0);
            else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk($sformatf("dut%0d_port_order", d), 64'(p), 64'(e.port));
                chk($sformatf("dut%0d_p%0d_data", d, p), 64'(dd[p]), 64'(e.data));
                chk($sformatf("dut%0d_p%0d_resp", d, p), 64'(r[p]), 64'(e.resp));
                chk($sformatf("dut%0d_p%0d_cycle", d, p), 64'(cyc), 64'(e.due));
            end
        end
    endtask

    always @(negedge c_clk) begin
        if (reset) begin
            mon(0, resp0, dout0);
            mon(1, resp1, dout1);
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic req(input int d, input int p, input logic [3:0] c, input logic [DW-1:0] a);
        if (d == 0) begin cmd0[p] = c; din0[p] = a; end
        else        begin cmd1[p] = c; din1[p] = a; end
    endtask

    task automatic op2(input int d, input int p, input logic [DW-1:0] b);
        if (d == 0) begin cmd0[p] = 4'd0; din0[p] = b; end
        else        begin cmd1[p] = 4'd0; din1[p] = b; end
    endtask

    task automatic expect_r(input int d, input int p, input logic [DW-1:0] data,
                            input logic [1:0] resp, input int due);
        exp_t e;
        e.port = p; e.data = data; e.resp = resp; e.due = due;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        chk("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
        tick();
        tick();
    endtask

    // Uncontended op: response expected 3 edges after the command edge.
    task automatic single(input int d, input int p, input logic [3:0] c, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] ed, input logic [1:0] er);
        expect_r(d, p, ed, er, cyc + 1 + 3);
        req(d, p, c, a);
        tick();
        op2(d, p, b);
        tick();
        op2(d, p, '0);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        cmd0 = '0; cmd1 = '0; din0 = '0; din1 = '0;
        reset = 1'b0;

        repeat (4) begin
            for (int p = 0; p < NP; p++) begin
                cmd0[p] = 4'($urandom_range(0, 15)); din0[p] = $urandom;
                cmd1[p] = 4'($urandom_range(0, 15)); din1[p] = $urandom;
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                chk("rst_data0", 64'(dout0[p]), 64'd0);
                chk("rst_resp0", 64'(resp0[p]), 64'd0);
                chk("rst_data1", 64'(dout1[p]), 64'd0);
                chk("rst_resp1", 64'(resp1[p]), 64'd0);
            end
        end
        cmd0 = '0; cmd1 = '0; din0 = '0; din1 = '0;
        reset = 1'b1;

        single(0, 0, 4'd1, 32'h5,        32'h7,        32'hC,        2'd1);
        single(0, 1, 4'd1, 32'hFFFFFFFF, 32'h1,        32'h0,        2'd2);
        single(0, 1, 4'd1, 32'hFFFFFFFE, 32'h1,        32'hFFFFFFFF, 2'd1);
        single(0, 2, 4'd2, 32'h3,        32'h5,        32'h0,        2'd2);
        single(0, 2, 4'd2, 32'h5,        32'h3,        32'h2,        2'd1);
        single(0, 2, 4'd2, 32'h5,        32'h5,        32'h0,        2'd1);
        single(0, 3, 4'd5, 32'h1,        32'hFFFFFFE4, 32'h10,       2'd1);
        single(0, 3, 4'd6, 32'h80000000, 32'd31,       32'h1,        2'd1);
        single(0, 3, 4'd6, 32'hF0,       32'h24,       32'hF,        2'd1);
        single(0, 3, 4'hA, 32'h1,        32'h2,        32'h0,        2'd2);
        single(0, 0, 4'd3, 32'h1,        32'h2,        32'h0,        2'd2);

        // Fixed priority, all ports at once: ports 0..3 answer 3..6 edges after the command.
        for (int p = 0; p < NP; p++) begin
            expect_r(0, p, 32'(16 * (p + 1) + 1), 2'd1, cyc + 1 + 3 + p);
            req(0, p, 4'd1, 32'(16 * (p + 1)));
        end
        tick();
        for (int p = 0; p < NP; p++) op2(0, p, 32'h1);
        tick();
        for (int p = 0; p < NP; p++) op2(0, p, '0);
        drain();

        // Round robin, ports 1..3 one cycle ahead of port 0: order 1,2,3,0 (fixed would give 1,0,2,3).
        c0 = cyc + 1;
        for (int p = 1; p < NP; p++) begin
            expect_r(1, p, 32'(11 * (p + 1)), 2'd1, c0 + 2 + p);
            req(1, p, 4'd1, 32'(10 * (p + 1)));
        end
        tick();
        for (int p = 1; p < NP; p++) op2(1, p, 32'(p + 1));
        expect_r(1, 0, 32'd11, 2'd1, c0 + 6);
        req(1, 0, 4'd1, 32'd10);
        tick();
        op2(1, 0, 32'd1);
        tick();
        op2(1, 0, '0);
        drain();

        // Round robin, commands held continuously; pointer sits at port 1. Two rounds, then the
        // held command must produce nothing extra while ports are in PEND/RESP.
        c0 = cyc + 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NP; k++) begin
                automatic int p = (k + 1) % NP;
                expect_r(1, p, 32'(32'h200 * (p + 1)), 2'd1, c0 + 3 + k + 5 * r);
            end
        end
        for (int p = 0; p < NP; p++) begin
            cmd1[p] = 4'd1;
            din1[p] = 32'(32'h100 * (p + 1));
        end
        repeat (9) tick();
        cmd1 = '0;
        drain();
        din1 = '0;

        // Reset while port 0 is pending: the in-flight command must vanish.
        req(0, 0, 4'd1, 32'd9);
        req(1, 2, 4'd2, 32'd9);
        tick();
        op2(0, 0, 32'd9);
        op2(1, 2, 32'd1);
        tick();
        reset = 1'b0;
        #2;
        for (int p = 0; p < NP; p++) begin
            chk("pend_rst_resp0", 64'(resp0[p]), 64'd0);
            chk("pend_rst_resp1", 64'(resp1[p]), 64'd0);
        end
        tick();
        op2(0, 0, '0);
        op2(1, 2, '0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        single(0, 0, 4'd1, 32'h1, 32'h1, 32'h2, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
